// File: rtl/rf16b_piso_tx.sv
// Parallel-in serial-out transmitter: captures a word on load/ready and shifts it out one bit per clk_en edge.
// Optional even-parity trailer bit is built when RF16B_TX_PARITY_EN is defined.
module rf16b_piso_tx #(
  parameter int WIDTH     = 16,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk_n,
  input  logic             rst,
  input  logic             clk_en,
  input  logic [WIDTH-1:0] D,
  input  logic             load,
  output logic             ready,
  output logic             busy,
  output logic             sdo,
  output logic             sdo_valid,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH);

`ifdef RF16B_TX_PARITY_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PAR = 2'd2} state_e;
`else
  typedef enum logic [0:0] {IDLE = 1'b0, SHIFT = 1'b1} state_e;
`endif

  state_e           state_q;
  logic [WIDTH-1:0] shift_q;
  logic [CW-1:0]    cnt_q;
  logic             sdo_q;
  logic             sdo_valid_q;
  logic             busy_q;
  logic             done_q;
`ifdef RF16B_TX_PARITY_EN
  logic             parity_q;
`endif

  logic             bit_d;
  logic [WIDTH-1:0] shift_d;

  // Bit order is a elaboration-time choice; only one branch survives synthesis.
  always_comb begin
    bit_d   = 1'b0;
    shift_d = shift_q;
    if (MSB_FIRST) begin
      bit_d   = shift_q[WIDTH-1];
      shift_d = {shift_q[WIDTH-2:0], 1'b0};
    end else begin
      bit_d   = shift_q[0];
      shift_d = {1'b0, shift_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk_n or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      cnt_q       <= '0;
      sdo_q       <= 1'b1;
      sdo_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef RF16B_TX_PARITY_EN
      parity_q    <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking default here is overridden by a later assignment in the
      // same block, which is how done becomes a single-cycle pulse.
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (load) begin
            shift_q <= D;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= SHIFT;
`ifdef RF16B_TX_PARITY_EN
            parity_q <= ^D;
`endif
          end
        end
        SHIFT: begin
          if (clk_en) begin
            if (cnt_q == LAST_CNT) begin
`ifdef RF16B_TX_PARITY_EN
              state_q     <= PAR;
              sdo_q       <= parity_q;
              sdo_valid_q <= 1'b1;
`else
              state_q     <= IDLE;
              cnt_q       <= '0;
              sdo_q       <= 1'b1;
              sdo_valid_q <= 1'b0;
              busy_q      <= 1'b0;
              done_q      <= 1'b1;
`endif
            end else begin
              sdo_q       <= bit_d;
              sdo_valid_q <= 1'b1;
              shift_q     <= shift_d;
              cnt_q       <= cnt_q + CW'(1);
            end
          end
        end
`ifdef RF16B_TX_PARITY_EN
        PAR: begin
          if (clk_en) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            sdo_q       <= 1'b1;
            sdo_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
          end
        end
`endif
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ready     = (state_q == IDLE);
  assign busy      = busy_q;
  assign sdo       = sdo_q;
  assign sdo_valid = sdo_valid_q;
  assign done      = done_q;

endmodule

// File: tb/tb_rf16b_piso_tx.sv
// Self-checking bench for rf16b_piso_tx: frame-level model compared every cycle, plus literal frame checks.
module tb_rf16b_piso_tx;

  localparam int W = 16;
`ifdef RF16B_TX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int FRAME = W + PB;

  logic         clk_n  = 1'b0;
  logic         rst    = 1'b0;
  logic         clk_en = 1'b0;
  logic         load   = 1'b0;
  logic [W-1:0] d      = '0;
  logic         ready, busy, sdo, sdo_valid, done;

  rf16b_piso_tx #(.WIDTH(W), .MSB_FIRST(1'b1)) dut (
    .clk_n    (clk_n),
    .rst      (rst),
    .clk_en   (clk_en),
    .D        (d),
    .load     (load),
    .ready    (ready),
    .busy     (busy),
    .sdo      (sdo),
    .sdo_valid(sdo_valid),
    .done     (done)
  );

  always #5 clk_n = ~clk_n;

  int total = 0;
  int bad   = 0;
  int edge_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Frame model: a frame is a list of bits handed out one per enabled edge,
  // followed by one enabled edge that closes the frame.
  bit m_bits[$];
  bit m_active = 1'b0;
  int m_pos    = 0;
  bit m_sdo    = 1'b1;
  bit m_vld    = 1'b0;
  bit m_done   = 1'b0;

  always @(posedge clk_n or posedge rst) begin
    if (rst) begin
      m_bits.delete();
      m_active = 1'b0;
      m_pos    = 0;
      m_sdo    = 1'b1;
      m_vld    = 1'b0;
      m_done   = 1'b0;
    end else begin
      m_done = 1'b0;
      if (!m_active) begin
        if (load) begin
          m_bits.delete();
          for (int i = 0; i < W; i++) m_bits.push_back(d[W-1-i]);
          if (PB != 0) m_bits.push_back(^d);
          m_active = 1'b1;
          m_pos    = 0;
        end
      end else if (clk_en) begin
        if (m_pos < m_bits.size()) begin
          m_sdo = m_bits[m_pos];
          m_vld = 1'b1;
          m_pos++;
        end else begin
          m_active = 1'b0;
          m_sdo    = 1'b1;
          m_vld    = 1'b0;
          m_done   = 1'b1;
        end
      end
    end
  end

  always @(posedge clk_n) edge_cnt++;

  // Per-cycle compare and serial collector, sampled 2 time units after the edge.
  bit rx[$];
  int done_seen = 0;

  always @(posedge clk_n) begin
    #2;
    check("sdo",       sdo,       m_sdo);
    check("sdo_valid", sdo_valid, m_vld);
    check("busy",      busy,      m_active);
    check("done",      done,      m_done);
    check("ready",     ready,     !m_active);
    if (sdo_valid && clk_en) rx.push_back(sdo);
    if (done) done_seen++;
  end

  function automatic logic [W-1:0] rx_word();
    logic [W-1:0] w = '0;
    for (int i = 0; i < W; i++)
      if (i < rx.size()) w[W-1-i] = rx[i];
    return w;
  endfunction

  task automatic tick();
    @(negedge clk_n);
  endtask

  // Called just after a falling edge; k is the edge that captures the word.
  task automatic start(input logic [W-1:0] w, output int k);
    d    = w;
    load = 1'b1;
    k    = edge_cnt + 1;
    @(negedge clk_n);
    load = 1'b0;
  endtask

  task automatic wait_done(input bit alt, input int budget, output int de);
    de = -1;
    for (int i = 0; i < budget; i++) begin
      if (done) begin
        de = edge_cnt;
        break;
      end
      if (alt) clk_en = ~clk_en;
      @(negedge clk_n);
    end
    if (de < 0) check("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, k2, de;

    // Reset held for three cycles
    #1 rst = 1'b1;
    repeat (3) begin
      @(negedge clk_n);
      check("rst_sdo",   sdo,       1'b1);
      check("rst_valid", sdo_valid, 1'b0);
      check("rst_busy",  busy,      1'b0);
      check("rst_done",  done,      1'b0);
      check("rst_ready", ready,     1'b1);
    end
    rst = 1'b0;
    tick();

    // Continuous enable, A5C3
    clk_en = 1'b1;
    rx.delete();
    done_seen = 0;
    start(16'hA5C3, k);
    wait_done(1'b0, 100, de);
    check("a5c3_latency", de - k, FRAME + 1);
    check("a5c3_word", rx_word(), 16'hA5C3);
    check("a5c3_nbits", rx.size(), FRAME);
    check("a5c3_ready", ready, 1'b1);
    tick();
    check("a5c3_done_once", done_seen, 1);
    check("a5c3_done_low", done, 1'b0);

    // Alternate-edge enable, 8001
    clk_en = 1'b0;
    rx.delete();
    done_seen = 0;
    start(16'h8001, k);
    wait_done(1'b1, 200, de);
    check("alt_latency", de - k, 2 * FRAME + 1);
    check("alt_word", rx_word(), 16'h8001);
    tick();
    check("alt_done_once", done_seen, 1);

    // Load while busy ignored, then back-to-back load in done cycle
    clk_en = 1'b1;
    rx.delete();
    start(16'h1234, k);
    repeat (5) tick();
    d    = 16'hFFFF;
    load = 1'b1;
    tick();
    load = 1'b0;
    wait_done(1'b0, 100, de);
    check("busy_load_latency", de - k, FRAME + 1);
    check("busy_load_word", rx_word(), 16'h1234);
    rx.delete();
    d    = 16'h5678;
    load = 1'b1;
    k2   = edge_cnt + 1;
    tick();
    load = 1'b0;
    wait_done(1'b0, 100, de);
    check("b2b_latency", de - k2, FRAME + 1);
    check("b2b_word", rx_word(), 16'h5678);
    check("b2b_first_bit", rx[0], 1'b0);

    // Asynchronous reset on the 7th bit of an FFFF frame
    tick();
    rx.delete();
    start(16'hFFFF, k);
    for (int i = 0; i < 50 && rx.size() < 7; i++) tick();
    check("mid_reached_bit7", rx.size(), 7);
    #1 rst = 1'b1;
    #1;
    check("async_sdo",   sdo,       1'b1);
    check("async_valid", sdo_valid, 1'b0);
    check("async_busy",  busy,      1'b0);
    check("async_ready", ready,     1'b1);
    @(negedge clk_n);
    rst = 1'b0;
    tick();
    rx.delete();
    start(16'h0F0F, k);
    wait_done(1'b0, 100, de);
    check("post_rst_latency", de - k, FRAME + 1);
    check("post_rst_word", rx_word(), 16'h0F0F);

    // Parity frame (or plain frame when parity is not built)
    tick();
    rx.delete();
    start(16'h0007, k);
    wait_done(1'b0, 100, de);
    check("w0007_latency", de - k, FRAME + 1);
    check("w0007_word", rx_word(), 16'h0007);
`ifdef RF16B_TX_PARITY_EN
    check("w0007_nbits", rx.size(), 17);
    if (rx.size() > 16) check("w0007_parity", rx[16], 1'b1);
`else
    check("w0007_nbits", rx.size(), 16);
`endif

    tick();
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rf16b_piso_tx.md
Name: rf16b_piso_tx

Overview:
- Parallel-in, serial-out transmitter for the 16-bit register-file datapath.
- Accepts a 16-bit word on D through a load/ready handshake and shifts it out one bit per enabled clock on sdo, framed by sdo_valid.
- Pulses done when the frame completes.
- Counterpart of the clock-enabled parallel capture register: that block takes words in, this block sends words out serially.
- Bit rate is set by clk_en, the same qualifier style used across the register blocks.

Parameters:
- WIDTH, 16, word width in bits. Legal range is 2..32.
- MSB_FIRST, 1, bit order. 1 sends D[WIDTH-1] first; 0 sends D[0] first.

Ports:
- clk_n  input  1  system clock; all state updates on its rising edge
- rst  input  1  asynchronous reset, active-high
- clk_en  input  1  bit-rate enable; one serial bit advances per rising edge with clk_en=1
- D  input  WIDTH  parallel word to transmit
- load  input  1  load request; accepted only when ready=1
- ready  output  1  combinational, equals (state==IDLE)
- busy  output  1  registered; high while a frame is in progress
- sdo  output  1  registered serial data; idles at 1
- sdo_valid  output  1  registered; high while sdo carries a frame bit
- done  output  1  registered one-cycle pulse at frame end

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-frame):
  - state=IDLE, shift register=0, bit counter=0.
  - sdo=1, sdo_valid=0, busy=0, done=0; ready is therefore 1.
- States: IDLE, SHIFT, PAR (PAR exists only with the optional feature).
- IDLE:
  - On an edge with load=1, capture D into the shift register and go to SHIFT. The capture happens regardless of clk_en.
  - busy<=1 on that edge. sdo stays 1 and sdo_valid stays 0.
- SHIFT:
  - On each edge with clk_en=1:
    - sdo<=next bit (the MSB, or the LSB when MSB_FIRST=0).
    - sdo_valid<=1.
    - Shift the register by one.
    - Increment the counter. The counter is $clog2(WIDTH+1) bits wide.
  - Edges with clk_en=0 freeze all state; sdo and sdo_valid hold.
  - After WIDTH bits have been emitted, the next clk_en edge does the following:
    - Without parity: go to IDLE with sdo<=1, sdo_valid<=0, busy<=0, done<=1.
    - With parity: go to PAR.
- done is high for exactly one clk_n cycle, then cleared.
- Latency with clk_en held at 1 and load accepted at edge k:
  - Bit i is on sdo from edge k+1+i.
  - done and ready are high after edge k+WIDTH+1.
- load while busy is ignored, and D is not sampled. No queueing.
- load in the same cycle that done is high is accepted, because state is already IDLE. A new frame starts back-to-back.
- The first bit is emitted only on the first clk_en=1 edge after capture. Capture and first bit never occur on the same edge.
- clk_en held at 0 indefinitely keeps the block in SHIFT with outputs stable.

Optional Feature:
- Macro: RF16B_TX_PARITY_EN.
- Defined:
  - After the WIDTH data bits, the next clk_en edge emits one even-parity bit on sdo with sdo_valid=1. The parity bit is the XOR of the captured word.
  - The following clk_en edge ends the frame (sdo<=1, sdo_valid<=0, busy<=0, done<=1).
  - Frame length is WIDTH+1 bits; done follows edge k+WIDTH+2.
- Undefined:
  - The PAR state and parity logic are absent.
  - The frame is WIDTH bits; done follows edge k+WIDTH+1.

Test Plan:
1. Hold rst=1 for 3 cycles, then release → sdo=1, sdo_valid=0, busy=0, done=0, ready=1 throughout. Assert rst asynchronously between edges → outputs reset without waiting for an edge.
2. Hold clk_en=1. Load D=16'hA5C3 at edge k → sdo reads 1010_0101_1100_0011 on edges k+1..k+16 with sdo_valid=1. done=1 for one cycle after edge k+17, ready=1.
3. Set clk_en high on alternate edges. Load D=16'h8001 → each bit is held for 2 cycles. Sequence is 1, fourteen 0s, 1. The frame spans 32 cycles and done is pulsed once.
4. Start a frame with 16'h1234. Assert load with D=16'hFFFF mid-frame → the request is ignored and the sequence matches 16'h1234. Then assert load=1 with D=16'h5678 in the done cycle → the new frame starts back-to-back and its first bit is 0.
5. Assert rst at the 7th bit of a 16'hFFFF frame → sdo=1, sdo_valid=0, busy=0 immediately. A subsequent load of 16'h0F0F transmits 0000_1111_0000_1111 cleanly.
6. With RF16B_TX_PARITY_EN defined, load D=16'h0007 → 16 data bits, then a parity bit of 1; done after edge k+18. With the macro undefined, the same stimulus gives done after edge k+17 and no parity bit.
